// File: rtl/calc_pkg.sv
// Shared opcodes, FSM states, flag positions and iteration count for the
// calculator ALU.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_DIV0  = 2;
  localparam int FLG_ERR   = 3;

  localparam int ITER_CNT = 8;

endpackage

// File: rtl/calc_muldiv_iter.sv
// One combinational step of an unsigned shift-add multiply or restoring divide.
// MUL: {acc,sreg} is the product/multiplier pair. DIV: acc is the remainder and
// sreg shifts the dividend out while the quotient bits shift in.
module calc_muldiv_iter
  import calc_pkg::*;
(
  input  logic       div,
  input  logic [7:0] acc,
  input  logic [7:0] sreg,
  input  logic [7:0] operand,
  output logic [7:0] acc_next,
  output logic [7:0] sreg_next
);

  logic [8:0] sum9;
  logic [8:0] rem9;
  logic [8:0] diff9;
  logic       qbit;

  always_comb begin
    sum9  = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : 9'd0);
    rem9  = {acc, sreg[7]};
    diff9 = rem9 - {1'b0, operand};
    // No borrow means the shifted remainder covers the divisor.
    qbit  = ~diff9[8];

    if (div) begin
      acc_next  = qbit ? diff9[7:0] : rem9[7:0];
      sreg_next = {sreg[6:0], qbit};
    end else begin
      acc_next  = sum9[8:1];
      sreg_next = {sum9[0], sreg[7:1]};
    end
  end

endmodule

// File: rtl/calc_alu.sv
// Sequential 8-bit ALU: single-cycle add/sub/logic, 8-step multiply and divide,
// registered 16-bit result with {err, div0, carry, zero} flags and a done pulse.
module calc_alu
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] opts,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        done
);

  state_t      state;
  state_t      state_next;
  logic [7:0]  a_p0;
  logic [7:0]  b_p0;
  logic [2:0]  op_p0;
  logic [2:0]  count;
  logic [7:0]  acc;
  logic [7:0]  sreg;
  logic [7:0]  acc_nx;
  logic [7:0]  sreg_nx;
  logic        iterative;
  logic        finish;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [15:0] res_calc;
  logic [3:0]  flg_calc;

  calc_muldiv_iter u_iter (
    .div       (op_p0 == OP_DIV),
    .acc       (acc),
    .sreg      (sreg),
    .operand   (op_p0 == OP_DIV ? b_p0 : a_p0),
    .acc_next  (acc_nx),
    .sreg_next (sreg_nx)
  );

  // Divide by zero skips iteration and completes on the first EXEC cycle.
  assign iterative = (op_p0 == OP_MUL) || ((op_p0 == OP_DIV) && (b_p0 != 8'h00));
  assign finish    = (state == EXEC) &&
                     (!iterative || (count == 3'(ITER_CNT - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = EXEC;
      EXEC:    if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sum9     = {1'b0, a_p0} + {1'b0, b_p0};
    diff9    = {1'b0, a_p0} - {1'b0, b_p0};
    res_calc = 16'h0000;
    flg_calc = 4'b0000;
    case (op_p0)
      OP_ADD: begin
        res_calc            = {8'h00, sum9[7:0]};
        flg_calc[FLG_CARRY] = sum9[8];
      end
      OP_SUB: begin
        res_calc            = {8'h00, diff9[7:0]};
        flg_calc[FLG_CARRY] = diff9[8];
      end
      OP_AND: res_calc = {8'h00, a_p0 & b_p0};
      OP_OR:  res_calc = {8'h00, a_p0 | b_p0};
      OP_XOR: res_calc = {8'h00, a_p0 ^ b_p0};
      OP_MUL: res_calc = {acc_nx, sreg_nx};
      OP_DIV: begin
        if (b_p0 == 8'h00) begin
          res_calc           = {8'hFF, a_p0};
          flg_calc[FLG_DIV0] = 1'b1;
        end else begin
          res_calc = {sreg_nx, acc_nx};
        end
      end
      default: flg_calc[FLG_ERR] = 1'b1;
    endcase
    flg_calc[FLG_ZERO] = (res_calc == 16'h0000) && (op_p0 != OP_RSV);
  end

  // Accept in IDLE, iterate/complete in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= 16'h0000;
      flags  <= 4'b0000;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_p0   <= 8'h00;
      b_p0   <= 8'h00;
      op_p0  <= 3'b000;
      count  <= 3'd0;
      acc    <= 8'h00;
      sreg   <= 8'h00;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_p0  <= opts[15:8];
          b_p0  <= opts[7:0];
          op_p0 <= op;
          count <= 3'd0;
          acc   <= 8'h00;
          sreg  <= (op == OP_DIV) ? opts[15:8] : opts[7:0];
          busy  <= 1'b1;
        end
      end else begin
        if (iterative) begin
          acc   <= acc_nx;
          sreg  <= sreg_nx;
          count <= count + 3'd1;
        end
        if (finish) begin
          result <= res_calc;
          flags  <= flg_calc;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_alu.sv
// Bench for calc_alu: directed vector table, hand-built corner sequences and
// randomized operations against an arithmetic reference model.
module tb_calc_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] opts;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  calc_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .opts   (opts),
    .result (result),
    .flags  (flags),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model built from plain integer arithmetic.
  task automatic model(input int a, input int b, input int o,
                       output logic [15:0] r, output logic [3:0] f, output int lat);
    int v;
    f   = 4'b0000;
    lat = 1;
    v   = 0;
    case (o)
      0: begin v = (a + b) % 256; f[1] = (a + b) > 255; end
      1: begin v = (a - b + 256) % 256; f[1] = a < b; end
      2: v = a & b;
      3: v = a | b;
      4: v = a ^ b;
      5: begin v = a * b; lat = 8; end
      6: begin
        if (b == 0) begin v = 65280 + a; f[2] = 1'b1; end
        else begin v = (a / b) * 256 + (a % b); lat = 8; end
      end
      default: f[3] = 1'b1;
    endcase
    r    = 16'(v);
    f[0] = (v == 0) && (o != 7);
  endtask

  // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        output logic [15:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    opts  = {a, b};
    op    = o;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opts  = 16'($urandom);
    op    = 3'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    f = flags;
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] r, er;
    logic [3:0]  f, ef;
    int          lat, elat, ndone, first;
    logic [7:0]  ra, rb;
    logic [2:0]  ro;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    opts     = 16'h0000;

    vecs[0]  = '{8'hFF, 8'h01, 3'd0, 16'h0000, 4'b0011, 1};
    vecs[1]  = '{8'h05, 8'h07, 3'd1, 16'h00FE, 4'b0010, 1};
    vecs[2]  = '{8'hF0, 8'h3C, 3'd2, 16'h0030, 4'b0000, 1};
    vecs[3]  = '{8'hFF, 8'hFF, 3'd5, 16'hFE01, 4'b0000, 8};
    vecs[4]  = '{8'h64, 8'h07, 3'd6, 16'h0E02, 4'b0000, 8};
    vecs[5]  = '{8'h2A, 8'h00, 3'd6, 16'hFF2A, 4'b0100, 1};
    vecs[6]  = '{8'h12, 8'h34, 3'd7, 16'h0000, 4'b1000, 1};
    vecs[7]  = '{8'hAA, 8'h55, 3'd4, 16'h00FF, 4'b0000, 1};
    vecs[8]  = '{8'h00, 8'h00, 3'd3, 16'h0000, 4'b0001, 1};
    vecs[9]  = '{8'h07, 8'h07, 3'd1, 16'h0000, 4'b0001, 1};
    vecs[10] = '{8'h00, 8'h05, 3'd6, 16'h0000, 4'b0001, 8};
    vecs[11] = '{8'h00, 8'h9C, 3'd5, 16'h0000, 4'b0001, 8};
    vecs[12] = '{8'h80, 8'h80, 3'd0, 16'h0000, 4'b0011, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 32'(result), 32'h0);
    check("reset_flags",  32'(flags),  32'h0);
    check("reset_busy",   32'(busy),   32'h0);
    check("reset_done",   32'(done),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, r, f, lat);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i),  32'(f), 32'(vecs[i].flg));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // MUL with a second start pulsed at E3: one done only, at E8.
    @(negedge clk);
    opts = 16'hFFFF; op = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        start = 1'b1; opts = 16'h0303; op = 3'd0;
      end
      @(posedge clk); #1;
      if (c == 3) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = c;
          check("mul_ignore_result", 32'(result), 32'hFE01);
        end
      end
    end
    check("mul_ignore_done_count", 32'(ndone), 32'd1);
    check("mul_ignore_done_edge",  32'(first), 32'd8);

    // Reset asserted at E4 of a MUL.
    @(negedge clk);
    opts = 16'h0F0F; op = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_flags",  32'(flags),  32'h0);
    check("midrst_busy",   32'(busy),   32'h0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin @(negedge clk); rst_n = 1'b1; end
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_op(8'h12, 8'h34, 3'd0, r, f, lat);
    check("postrst_add_result",  32'(r),   32'h0046);
    check("postrst_add_latency", 32'(lat), 32'd1);

    // Back-to-back: start held through the XOR done cycle launches a MUL.
    @(negedge clk);
    opts = 16'hAA55; op = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    opts = 16'h1010; op = 3'd5;
    @(posedge clk); #1;
    check("b2b_xor_done",   32'(done),   32'd1);
    check("b2b_xor_result", 32'(result), 32'h00FF);
    @(posedge clk); #1;
    start = 1'b0;
    opts  = 16'h0000;
    check("b2b_mul_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_mul_latency", 32'(lat),    32'd8);
    check("b2b_mul_result",  32'(result), 32'h0100);

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      ro = 3'($urandom_range(0, 7));
      model(int'(ra), int'(rb), int'(ro), er, ef, elat);
      run_op(ra, rb, ro, r, f, lat);
      check($sformatf("rnd%0d_op%0d_result", i, ro), 32'(r),   32'(er));
      check($sformatf("rnd%0d_op%0d_flags", i, ro),  32'(f),   32'(ef));
      check($sformatf("rnd%0d_op%0d_latency", i, ro), 32'(lat), 32'(elat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
